// File: rtl/nw_matrix_engine.sv
// nw_matrix_engine: Needleman-Wunsch score-matrix datapath; define NW_SCORE_SAT_EN for saturating score adds
module nw_matrix_engine #(
  parameter int N = 8,
  parameter int IW = 4,
  parameter int AW = 7,
  parameter int W = 8,
  parameter int MATCH = 1,
  parameter int MISMATCH = -1,
  parameter int GAP = -1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_init,
  input  logic          en_ins,
  input  logic          we,
  input  logic          en_read,
  input  logic          en_traceB,
  output logic          end_init,
  output logic          calc,
  output logic          end_fill,
  output logic          ending,
  output logic [IW-1:0] seq_a_idx,
  output logic [IW-1:0] seq_b_idx,
  input  logic [1:0]    seq_a_char,
  input  logic [1:0]    seq_b_char,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [W+1:0]  mem_wdata,
  input  logic [W+1:0]  mem_rdata,
  output logic          tb_valid,
  output logic [1:0]    tb_dir,
  output logic [W-1:0]  score_out
);
  typedef enum logic [2:0] {IDLE, INIT, READ, FILL, TRACE} mode_t;
  localparam logic [IW-1:0] NI = IW'(N);
  localparam logic signed [W-1:0] GAP_S = W'(GAP);
  localparam logic signed [W-1:0] MATCH_S = W'(MATCH);
  localparam logic signed [W-1:0] MISMATCH_S = W'(MISMATCH);
  mode_t mode;
  logic [IW-1:0] i, j;
  logic [1:0] c, dir_q, best_dir;
  logic tp, origin;
  logic signed [W-1:0] acc, d_q, u_q, res_q, diag, up, left, best;
  logic [AW-1:0] addr_q;
  logic [W+1:0] wdata_q;
  function automatic logic signed [W-1:0] add(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
`ifdef NW_SCORE_SAT_EN
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    return (s[W] != s[W-1]) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
`else
    return a + b;
`endif
  endfunction
  function automatic logic [AW-1:0] at(input logic [IW-1:0] r, input logic [IW-1:0] k);
    return AW'(int'(r) * (N + 1) + int'(k));
  endfunction
  // mode decode by enable priority, plus the three-way max and its winner direction
  always_comb begin
    mode = en_init ? INIT : en_read ? READ : we ? FILL : en_traceB ? TRACE : IDLE;
    origin = (i == '0) && (j == '0);
    diag = add(d_q, (seq_a_char == seq_b_char) ? MATCH_S : MISMATCH_S);
    up = add(u_q, GAP_S);
    left = add(mem_rdata[W-1:0], GAP_S);
    best = (diag >= up && diag >= left) ? diag : (up >= left) ? up : left;
    best_dir = (diag >= up && diag >= left) ? 2'b00 : (up >= left) ? 2'b01 : 2'b10;
  end
  // RAM port, status strobes and sequence indices; idle holds the last address/data
  always_comb begin
    mem_addr = addr_q;
    mem_we = 1'b0;
    mem_wdata = wdata_q;
    if (mode == INIT) begin
      mem_addr = at(i, j);
      mem_we = we;
      mem_wdata = {origin ? 2'b11 : (i == '0) ? 2'b10 : 2'b01, acc};
    end
    if (mode == READ)
      mem_addr = (c == 2'd0) ? at(i - 1'b1, j - 1'b1) : (c == 2'd1) ? at(i - 1'b1, j) : at(i, j - 1'b1);
    if (mode == FILL) begin
      mem_addr = at(i, j);
      mem_we = 1'b1;
      mem_wdata = {dir_q, res_q};
    end
    if (mode == TRACE && !ending)
      mem_addr = at(i, j);
    end_init = (mode == INIT) && we && (i == NI) && (j == '0);
    calc = (mode == READ) && (c == 2'd3);
    end_fill = (mode == FILL) && (i == NI) && (j == NI);
    seq_a_idx = en_ins ? i - 1'b1 : '0;
    seq_b_idx = en_ins ? j - 1'b1 : '0;
  end
  // cell sequencing, neighbour capture, result register and traceback walk
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i <= '0;
      j <= '0;
      c <= '0;
      tp <= 1'b0;
      acc <= '0;
      d_q <= '0;
      u_q <= '0;
      res_q <= '0;
      dir_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      tb_valid <= 1'b0;
      tb_dir <= '0;
      ending <= 1'b0;
      score_out <= '0;
    end else begin
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      c <= (mode == READ) ? c + {1'b0, c != 2'd3} : 2'd0;
      tp <= (mode == TRACE && !ending && !origin) ? ~tp : 1'b0;
      tb_valid <= 1'b0;
      if (mode == INIT && we) begin
        acc <= end_init ? '0 : (i == '0 && j == NI) ? GAP_S : add(acc, GAP_S);
        i <= end_init ? IW'(1) : (i == '0 && j != NI) ? i : i + 1'b1;
        j <= end_init ? IW'(1) : (i == '0 && j != NI) ? j + 1'b1 : '0;
      end
      if (mode == READ && c == 2'd1)
        d_q <= mem_rdata[W-1:0];
      if (mode == READ && c == 2'd2)
        u_q <= mem_rdata[W-1:0];
      if (mode == READ && c == 2'd3) begin
        res_q <= best;
        dir_q <= best_dir;
      end
      if (mode == FILL) begin
        i <= end_fill ? NI : (j == NI) ? i + 1'b1 : i;
        j <= end_fill ? NI : (j == NI) ? IW'(1) : j + 1'b1;
      end
      if (mode == TRACE && !ending && !tp && origin) begin
        ending <= 1'b1;
        tb_valid <= 1'b1;
        tb_dir <= 2'b11;
      end
      if (mode == TRACE && !ending && tp) begin
        tb_valid <= 1'b1;
        tb_dir <= mem_rdata[W+1:W];
        score_out <= (i == NI && j == NI) ? mem_rdata[W-1:0] : score_out;
        i <= (mem_rdata[W+1:W] == 2'b10) ? i : i - 1'b1;
        j <= (mem_rdata[W+1:W] == 2'b01) ? j : j - 1'b1;
      end
    end
endmodule

// File: tb/tb_nw_matrix_engine.sv
// tb_nw_matrix_engine: randomized self-checking bench for nw_matrix_engine with a DP reference model
module tb_nw_matrix_engine;
  localparam int N = 2, IW = 2, AW = 4, W = 8, GAP = -1;
  logic clk = 1'b0, rst = 1'b1;
  logic en_init = 1'b0, en_ins = 1'b0, we = 1'b0, en_read = 1'b0, en_traceB = 1'b0;
  logic end_init, calc, end_fill, ending, mem_we, tb_valid;
  logic [IW-1:0] seq_a_idx, seq_b_idx;
  logic [1:0] seq_a_char, seq_b_char, tb_dir;
  logic [AW-1:0] mem_addr;
  logic [W+1:0] mem_wdata;
  logic [W+1:0] mem_rdata = '0;
  logic [W-1:0] score_out;
  logic [1:0] sa[4], sb[4];
  logic [W+1:0] ram[16];
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [W+1:0] pre_data = '0;
  int checks = 0, failures = 0;
  int h[N+1][N+1], dm[N+1][N+1];

  nw_matrix_engine #(.N(N), .IW(IW), .AW(AW), .W(W)) dut (
    .clk(clk), .rst(rst), .en_init(en_init), .en_ins(en_ins), .we(we), .en_read(en_read),
    .en_traceB(en_traceB), .end_init(end_init), .calc(calc), .end_fill(end_fill), .ending(ending),
    .seq_a_idx(seq_a_idx), .seq_b_idx(seq_b_idx), .seq_a_char(seq_a_char), .seq_b_char(seq_b_char),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tb_valid(tb_valid), .tb_dir(tb_dir), .score_out(score_out)
  );

  always #5 clk = ~clk;
  assign seq_a_char = sa[seq_a_idx];
  assign seq_b_char = sb[seq_b_idx];

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic int fit(int v);
`ifdef NW_SCORE_SAT_EN
    return v > 127 ? 127 : v < -128 ? -128 : v;
`else
    return ((v + 128) & 255) - 128;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model();
    int d, u, l;
    for (int r = 0; r <= N; r++)
      for (int k = 0; k <= N; k++)
        if (r == 0 || k == 0) begin
          h[r][k] = fit((r + k) * GAP);
          dm[r][k] = (r == 0) ? ((k == 0) ? 3 : 2) : 1;
        end else begin
          d = fit(h[r-1][k-1] + ((sa[r-1] == sb[k-1]) ? 1 : -1));
          u = fit(h[r-1][k] + GAP);
          l = fit(h[r][k-1] + GAP);
          if (d >= u && d >= l) begin h[r][k] = d; dm[r][k] = 0; end
          else if (u >= l) begin h[r][k] = u; dm[r][k] = 1; end
          else begin h[r][k] = l; dm[r][k] = 2; end
        end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {en_init, en_ins, we, en_read, en_traceB} = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({end_init, calc, end_fill, ending, tb_valid, mem_we, tb_dir, seq_a_idx, seq_b_idx, mem_addr, mem_wdata, score_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%0d wdata=%h score=%0d flags=%b required all zero", mem_addr, mem_wdata, score_out,
               {end_init, calc, end_fill, ending, tb_valid, mem_we});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_init();
    int r, k;
    for (int s = 0; s <= 2 * N; s++) begin
      r = (s <= N) ? 0 : s - N;
      k = (s <= N) ? s : 0;
      en_init = 1'b1;
      we = 1'b1;
      @(negedge clk);
      checks++;
      if (end_init !== (s == 2 * N)) begin
        failures++;
        $display("FAIL init_end step=%0d got=%b required=%b", s, end_init, s == 2 * N);
      end
      checks++;
      if (mem_addr !== AW'(r * (N + 1) + k) || mem_we !== 1'b1) begin
        failures++;
        $display("FAIL init_addr step=%0d got addr=%0d we=%b required addr=%0d we=1", s, mem_addr, mem_we, r * (N + 1) + k);
      end
      checks++;
      if (int'($signed(mem_wdata[W-1:0])) != fit((r + k) * GAP)) begin
        failures++;
        $display("FAIL init_score step=%0d got=%0d required=%0d", s, $signed(mem_wdata[W-1:0]), fit((r + k) * GAP));
      end
      tick();
    end
    en_init = 1'b0;
    we = 1'b0;
  endtask

  task automatic test_fill();
    for (int r = 1; r <= N; r++)
      for (int k = 1; k <= N; k++) begin
        en_ins = 1'b1;
        en_read = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checks++;
          if (calc !== (c == 3)) begin
            failures++;
            $display("FAIL calc_timing cell=(%0d,%0d) cycle=%0d got=%b required=%b", r, k, c, calc, c == 3);
          end
          if (c == 0) begin
            checks++;
            if (seq_a_idx !== IW'(r - 1) || seq_b_idx !== IW'(k - 1)) begin
              failures++;
              $display("FAIL seq_idx cell=(%0d,%0d) got=%0d,%0d required=%0d,%0d", r, k, seq_a_idx, seq_b_idx, r - 1, k - 1);
            end
          end
          tick();
        end
        en_read = 1'b0;
        we = 1'b1;
        @(negedge clk);
        checks++;
        if (end_fill !== (r == N && k == N) || mem_we !== 1'b1 || mem_addr !== AW'(r * (N + 1) + k)) begin
          failures++;
          $display("FAIL fill_write cell=(%0d,%0d) got end_fill=%b we=%b addr=%0d required end_fill=%b we=1 addr=%0d",
                   r, k, end_fill, mem_we, mem_addr, r == N && k == N, r * (N + 1) + k);
        end
        tick();
        we = 1'b0;
      end
    en_ins = 1'b0;
  endtask

  task automatic check_matrix();
    logic [W+1:0] v;
    for (int r = 0; r <= N; r++)
      for (int k = 0; k <= N; k++) begin
        v = ram[r * (N + 1) + k];
        checks++;
        if (int'($signed(v[W-1:0])) != h[r][k] || int'(v[W+1:W]) != dm[r][k]) begin
          failures++;
          $display("FAIL cell(%0d,%0d) got score=%0d dir=%0d required score=%0d dir=%0d", r, k, $signed(v[W-1:0]), v[W+1:W], h[r][k], dm[r][k]);
        end
      end
  endtask

  task automatic test_trace();
    int got[$], exp[$];
    int r = N, k = N;
    bit done = 1'b0;
    while (!(r == 0 && k == 0)) begin
      exp.push_back(dm[r][k]);
      if (dm[r][k] != 2) r--;
      if (dm[r + (dm[r+0][k] == 99 ? 0 : 0)][k] == 99) k = k;
      if (exp[$] != 1) k--;
    end
    exp.push_back(3);
    en_traceB = 1'b1;
    for (int t = 0; t < 8 * N + 8 && !done; t++) begin
      @(negedge clk);
      if (tb_valid) got.push_back(int'(tb_dir));
      if (ending) done = 1'b1;
      tick();
    end
    en_traceB = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL trace_ending got ending=%b required 1 within budget", ending);
    end
    checks++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("FAIL trace_len got=%0d required=%0d", got.size(), exp.size());
    end else
      for (int s = 0; s < exp.size(); s++) begin
        checks++;
        if (got[s] != exp[s]) begin
          failures++;
          $display("FAIL trace_dir step=%0d got=%0d required=%0d", s, got[s], exp[s]);
        end
      end
    checks++;
    if (int'($signed(score_out)) != h[N][N]) begin
      failures++;
      $display("FAIL score_out got=%0d required=%0d", $signed(score_out), h[N][N]);
    end
  endtask

  task automatic run_case(input logic [1:0] a0, a1, b0, b1, input bit fixed, input int nn);
    do_reset();
    sa[0] = a0; sa[1] = a1; sb[0] = b0; sb[1] = b1;
    model();
    test_init();
    test_fill();
    check_matrix();
    if (fixed) begin
      checks++;
      if (int'($signed(ram[N * (N + 1) + N][W-1:0])) != nn) begin
        failures++;
        $display("FAIL final_cell got=%0d required=%0d", $signed(ram[N * (N + 1) + N][W-1:0]), nn);
      end
    end
    test_trace();
  endtask

  task automatic test_overflow();
    int d, u, l, es, ed;
    do_reset();
    sa[0] = 2'd0; sb[0] = 2'd0;
    test_init();
    pre_we = 1'b1;
    pre_addr = '0;
    pre_data = {2'b11, 8'd127};
    tick();
    pre_we = 1'b0;
    en_ins = 1'b1;
    en_read = 1'b1;
    repeat (4) tick();
    en_read = 1'b0;
    we = 1'b1;
    tick();
    we = 1'b0;
    en_ins = 1'b0;
    d = fit(127 + 1);
    u = fit(GAP + GAP);
    l = fit(GAP + GAP);
    es = (d >= u && d >= l) ? d : u;
    ed = (d >= u && d >= l) ? 0 : 1;
    checks++;
    if (int'($signed(ram[N + 2][W-1:0])) != es || int'(ram[N + 2][W+1:W]) != ed) begin
      failures++;
      $display("FAIL overflow_cell got score=%0d dir=%0d required score=%0d dir=%0d", $signed(ram[N + 2][W-1:0]), ram[N + 2][W+1:W], es, ed);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    test_init();
    en_ins = 1'b1;
    en_read = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    {en_init, en_ins, we, en_read, en_traceB} = '0;
    @(negedge clk);
    checks++;
    if ({end_init, calc, end_fill, ending, tb_valid, mem_we, tb_dir, seq_a_idx, seq_b_idx, mem_addr, mem_wdata, score_out} !== '0) begin
      failures++;
      $display("FAIL midread_reset got addr=%0d wdata=%h flags=%b required all zero", mem_addr, mem_wdata,
               {end_init, calc, end_fill, ending, tb_valid, mem_we});
    end
    tick();
    rst = 1'b0;
    test_init();
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin sa[s] = 2'd0; sb[s] = 2'd0; end
    test_reset();
    run_case(2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 2);
    run_case(2'd0, 2'd0, 2'd1, 2'd1, 1'b1, -2);
    for (int n = 0; n < 8; n++)
      run_case(2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0, 0);
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
